line_drawer_stream: RTL and testbench
=====================================

Name: line_drawer_stream

Overview:
Parametrised successor line engine: rasterises one line segment per request using integer Bresenham in all eight octants. Emits one pixel per accepted valid/ready beat, so the frame-buffer writer or clear logic can stall it. Sits between the shape sequencer (issues start + endpoints) and the VGA frame-buffer write port. Replaces the fixed-width, free-running drawer; no built-in shift or clear timing.

Parameters:
XW, 10, x coordinate width (640-wide screen)
YW, 9, y coordinate width (480-tall screen)
CW, max(XW,YW), internal magnitude width (derived localparam, not overridable)
ERRW, CW+2, signed error-accumulator width (derived localparam)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
x0  in  XW  start x
y0  in  YW  start y
x1  in  XW  end x
y1  in  YW  end y
busy  out  1  high from accepted start until done pulse, inclusive
done  out  1  one-cycle pulse after last pixel accepted
pix_valid  out  1  pix_x/pix_y hold a pixel
pix_ready  in  1  downstream accepts pixel when pix_valid && pix_ready
pix_x  out  XW  pixel x
pix_y  out  YW  pixel y

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high. Reset wins over all inputs, including mid-line: state=IDLE, busy=0, done=0, pix_valid=0, pix_x=0, pix_y=0, err=0. Line in progress is abandoned; no done pulse.
- States: IDLE, PLOT, DONE.
- IDLE: busy=0, pix_valid=0. On start=1:
  - latch endpoints; dx=|x1-x0|, dy=|y1-y0| (unsigned CW bits).
  - sx=+1 if x1>=x0 else -1; sy likewise.
  - err=dx-dy (ERRW signed); pix_x=x0, pix_y=y0.
  - go PLOT next cycle. First pixel_valid is 1 cycle after start.
- PLOT: pix_valid=1; pix_x/pix_y stable while pix_ready=0 (no change under stall).
  - On handshake with (pix_x,pix_y)==(x1,y1): go DONE.
  - On handshake otherwise: e2=2*err (ERRW).
    - if e2 >= -dy: err -= dy, pix_x += sx.
    - if e2 <= dx: err += dx, pix_y += sy.
    - both true: both updates apply in the same cycle (err += dx-dy).
  - Sustained throughput: 1 pixel/cycle with pix_ready held high.
- DONE: pix_valid=0, done=1 for exactly one cycle, busy=1; next state IDLE. A start asserted in DONE is ignored; start is never queued.
- Pixel count per line = max(dx,dy)+1. Endpoints are inclusive and x1,y1 are always emitted.
- Degenerate x0==x1 && y0==y1: exactly one pixel, then done.
- Arithmetic: coordinates are unsigned and never leave the [min,max] range of the endpoints, so no wrap is possible. Endpoint inputs may change freely while busy; only latched copies are used.

Optional Feature:
Macro LINE_DRAWER_DASH_EN.
- Defined:
  - adds input dash_mask [7:0], latched at start.
  - 3-bit step index resets to 0 at start and increments on every Bresenham step.
  - Pixel is presented (pix_valid=1) only if dash_mask[idx]=1.
  - Masked pixels advance internally in one cycle without a handshake.
  - Endpoint reached on a masked step still goes to DONE.
  - dash_mask=8'hFF is identical to the undefined build.
- Undefined: no port and no index counter; every pixel is presented.

Decomposition:
- Package line_pkg: state enum typedef (IDLE, PLOT, DONE), coord_x_t/coord_y_t typedefs parametrised via localparams XW=10/YW=9, dash width constant 8.
- One combinational sub-module, line_step: takes err, dx, dy, sx, sy, x, y and returns next err, x, y. It is reused by the future circle/polygon engines.

Test Plan:
- Horizontal (0,0)->(4,0), pix_ready=1: exactly 5 pixels, x=0..4, y=0, on consecutive cycles. done asserts 1 cycle after the last beat, busy drops the cycle after.
- Steep negative (10,20)->(7,10): exactly 11 pixels, y=20..10 each decreasing by 1, x non-increasing, ending at (7,10).
- Single point (5,5)->(5,5): one pixel (5,5), then done pulse.
- Backpressure, diagonal (0,0)->(3,3), pix_ready toggling 1010...: 4 pixels (0,0),(1,1),(2,2),(3,3) in order. Outputs held stable while pix_ready=0; no pixel dropped or duplicated.
- Reset asserted after the 2nd pixel of (0,0)->(9,0): next cycle busy=0, pix_valid=0, no done. A new start afterwards draws cleanly from its own x0.
- LINE_DRAWER_DASH_EN, dash_mask=8'b0101_0101, (0,0)->(9,0): pixels x=0,2,4,6,8 presented. done after step x=9 (masked).

Source files
------------

// File: rtl/line_pkg.sv
// Shared types for the line/circle/polygon raster engines: FSM state,
// default screen coordinate types and the dash pattern width.
package line_pkg;

  localparam int XW     = 10;
  localparam int YW     = 9;
  localparam int DASH_W = 8;

  typedef logic [XW-1:0] coord_x_t;
  typedef logic [YW-1:0] coord_y_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/line_step.sv
// One combinational Bresenham step: given the error term, magnitudes and
// step directions, returns the next error and the next (x, y) position.
module line_step #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic signed [((XW > YW) ? XW : YW)+1:0] i_err,
  input  logic        [((XW > YW) ? XW : YW)-1:0] i_dx,
  input  logic        [((XW > YW) ? XW : YW)-1:0] i_dy,
  input  logic                                    i_sx_neg,
  input  logic                                    i_sy_neg,
  input  logic        [XW-1:0]                    i_x,
  input  logic        [YW-1:0]                    i_y,
  output logic signed [((XW > YW) ? XW : YW)+1:0] o_err,
  output logic        [XW-1:0]                    o_x,
  output logic        [YW-1:0]                    o_y
);

  localparam int CW   = (XW > YW) ? XW : YW;
  localparam int ERRW = CW + 2;

  logic signed [ERRW-1:0] w_e2;
  logic signed [ERRW-1:0] w_dx_s;
  logic signed [ERRW-1:0] w_dy_s;
  logic                   w_step_x;
  logic                   w_step_y;

  // Two guard bits keep 2*err and -dy representable without overflow.
  assign w_e2     = i_err <<< 1;
  assign w_dx_s   = $signed({2'b00, i_dx});
  assign w_dy_s   = $signed({2'b00, i_dy});
  assign w_step_x = (w_e2 >= -w_dy_s);
  assign w_step_y = (w_e2 <= w_dx_s);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_err = i_err;
    o_x   = i_x;
    o_y   = i_y;
    if (w_step_x) begin
      o_err = o_err - w_dy_s;
      o_x   = i_sx_neg ? i_x - 1'b1 : i_x + 1'b1;
    end
    if (w_step_y) begin
      o_err = o_err + w_dx_s;
      o_y   = i_sy_neg ? i_y - 1'b1 : i_y + 1'b1;
    end
  end

endmodule

// File: rtl/line_drawer_stream.sv
// Streaming Bresenham line rasteriser, one pixel per valid/ready beat.
// Optional dash pattern support is enabled by defining LINE_DRAWER_DASH_EN.
module line_drawer_stream #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
`ifdef LINE_DRAWER_DASH_EN
  input  logic [7:0]    dash_mask,
`endif
  output logic          busy,
  output logic          done,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y
);

  import line_pkg::*;

  localparam int CW   = (XW > YW) ? XW : YW;
  localparam int ERRW = CW + 2;

  state_e                 r_state;
  logic signed [ERRW-1:0] r_err;
  logic        [XW-1:0]   r_pix_x;
  logic        [YW-1:0]   r_pix_y;
  logic        [XW-1:0]   r_x1;
  logic        [YW-1:0]   r_y1;
  logic        [CW-1:0]   r_dx;
  logic        [CW-1:0]   r_dy;
  logic                   r_sx_neg;
  logic                   r_sy_neg;

  logic        [CW-1:0]   w_dx_abs;
  logic        [CW-1:0]   w_dy_abs;
  logic signed [ERRW-1:0] w_err_init;
  logic signed [ERRW-1:0] w_err_next;
  logic        [XW-1:0]   w_x_next;
  logic        [YW-1:0]   w_y_next;
  logic                   w_present;
  logic                   w_advance;
  logic                   w_at_end;

`ifdef LINE_DRAWER_DASH_EN
  logic [DASH_W-1:0] r_mask;
  logic [2:0]        r_idx;

  assign w_present = r_mask[r_idx];
`else
  assign w_present = 1'b1;
`endif

  assign w_dx_abs   = CW'((x1 >= x0) ? x1 - x0 : x0 - x1);
  assign w_dy_abs   = CW'((y1 >= y0) ? y1 - y0 : y0 - y1);
  assign w_err_init = $signed({2'b00, w_dx_abs}) - $signed({2'b00, w_dy_abs});

  assign w_at_end  = (r_pix_x == r_x1) && (r_pix_y == r_y1);
  // Masked pixels step on their own; presented ones wait for the handshake.
  assign w_advance = (r_state == PLOT) && (w_present ? pix_ready : 1'b1);

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign pix_valid = (r_state == PLOT) && w_present;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;

  line_step #(
    .XW (XW),
    .YW (YW)
  ) u_step (
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_sx_neg (r_sx_neg),
    .i_sy_neg (r_sy_neg),
    .i_x      (r_pix_x),
    .i_y      (r_pix_y),
    .o_err    (w_err_next),
    .o_x      (w_x_next),
    .o_y      (w_y_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_err   <= '0;
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_err   <= w_err_init;
            r_pix_x <= x0;
            r_pix_y <= y0;
            r_state <= PLOT;
          end
        end
        PLOT: begin
          if (w_advance) begin
            if (w_at_end) begin
              r_state <= DONE;
            end else begin
              r_err   <= w_err_next;
              r_pix_x <= w_x_next;
              r_pix_y <= w_y_next;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: line parameters are always loaded on start before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_x1     <= x1;
      r_y1     <= y1;
      r_dx     <= w_dx_abs;
      r_dy     <= w_dy_abs;
      r_sx_neg <= (x1 < x0);
      r_sy_neg <= (y1 < y0);
    end
  end

`ifdef LINE_DRAWER_DASH_EN
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_mask <= dash_mask;
      r_idx  <= '0;
    end else if (w_advance && !w_at_end) begin
      r_idx <= r_idx + 3'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_drawer_stream.sv
// Self-checking bench for line_drawer_stream: directed lines plus random
// lines and random backpressure against a pixel-list reference model.
module tb_line_drawer_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic [7:0] dash_mask;
  logic       busy, done, pix_valid, pix_ready;
  logic [9:0] pix_x;
  logic [8:0] pix_y;

  int total = 0;
  int bad   = 0;
  int exp_x[$];
  int exp_y[$];

  always #5 clk = ~clk;

  line_drawer_stream dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
`ifdef LINE_DRAWER_DASH_EN
    .dash_mask (dash_mask),
`endif
    .busy      (busy),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected presented pixels of one line, in order.
  task automatic build_ref(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [7:0] m, output int n_all);
    int x, y, dx, dy, sx, sy, err, e2, i;
    exp_x.delete();
    exp_y.delete();
    dx  = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    x   = ax0;
    y   = ay0;
    err = dx - dy;
    i   = 0;
    while (i < 4096) begin
      if (m[i % 8]) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
      i++;
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; x += sx; end
      if (e2 <= dx)  begin err += dx; y += sy; end
    end
    n_all = i;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int mode, input logic [7:0] m, input string tag);
    int  n_all, got, last_beat, cyc, hx, hy, dxa, dya;
    bit  stalled, seen_done, rdy;
    build_ref(ax0, ay0, ax1, ay1, m, n_all);
    dxa = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dya = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    start = 1'b1;
    x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1);
    dash_mask = m;
    @(negedge clk);
    start = 1'b0;
    x0 = 10'($urandom); y0 = 9'($urandom); x1 = 10'($urandom); y1 = 9'($urandom);
    dash_mask = 8'($urandom);
    check({tag, "_busy_first"}, busy, 1);
    if (m[0]) begin
      check({tag, "_valid_first"}, pix_valid, 1);
      check({tag, "_x_first"}, pix_x, ax0);
      check({tag, "_y_first"}, pix_y, ay0);
    end
    got = 0; last_beat = -10; stalled = 0; seen_done = 0; hx = 0; hy = 0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (done) begin
        seen_done = 1;
        break;
      end
      if (stalled) begin
        check({tag, "_hold_valid"}, pix_valid, 1);
        check({tag, "_hold_x"}, pix_x, hx);
        check({tag, "_hold_y"}, pix_y, hy);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      pix_ready = rdy;
      if (pix_valid && rdy) begin
        if (got < exp_x.size()) begin
          check({tag, "_pix_x"}, pix_x, exp_x[got]);
          check({tag, "_pix_y"}, pix_y, exp_y[got]);
        end else begin
          check({tag, "_extra_pixel"}, got, exp_x.size());
        end
        got++;
        last_beat = cyc;
      end
      stalled = pix_valid && !rdy;
      hx = int'(pix_x);
      hy = int'(pix_y);
      @(negedge clk);
    end
    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_pix_count"}, got, exp_x.size());
    if (m == 8'hFF) check({tag, "_count_formula"}, got, ((dxa > dya) ? dxa : dya) + 1);
    if (seen_done) begin
      check({tag, "_busy_at_done"}, busy, 1);
      check({tag, "_valid_at_done"}, pix_valid, 0);
      if (m[(n_all - 1) % 8]) check({tag, "_done_latency"}, cyc, last_beat + 1);
      // A start held during DONE must be ignored rather than queued.
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    @(negedge clk);
    check({tag, "_no_queued_start"}, busy, 0);
  endtask

  initial begin
    int rx0, ry0, rx1, ry1;
    reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; dash_mask = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_x", pix_x, 0);
    check("rst_y", pix_y, 0);
    reset = 1'b0;
    @(negedge clk);

    run_line(0, 0, 4, 0, 0, 8'hFF, "horiz");
    run_line(10, 20, 7, 10, 0, 8'hFF, "steep_neg");
    run_line(5, 5, 5, 5, 0, 8'hFF, "point");
    run_line(0, 0, 3, 3, 1, 8'hFF, "diag_bp");
    run_line(639, 479, 0, 0, 0, 8'hFF, "full_diag");

    // Reset in the middle of a line abandons it without a done pulse.
    start = 1'b1; x0 = 10'd0; y0 = 9'd0; x1 = 10'd9; y1 = 9'd0;
    @(negedge clk);
    start = 1'b0; pix_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_x", pix_x, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", pix_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_x", pix_x, 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_quiet_done", done, 0);
      check("midrst_quiet_busy", busy, 0);
    end
    run_line(3, 4, 6, 2, 0, 8'hFF, "after_rst");

    for (int i = 0; i < 12; i++) begin
      rx0 = $urandom_range(0, 639); ry0 = $urandom_range(0, 479);
      rx1 = $urandom_range(0, 639); ry1 = $urandom_range(0, 479);
      if (i < 4) begin
        rx1 = rx0 + $urandom_range(0, 20) - 10;
        ry1 = ry0 + $urandom_range(0, 20) - 10;
        if (rx1 < 0) rx1 = 0;
        if (ry1 < 0) ry1 = 0;
        if (rx1 > 639) rx1 = 639;
        if (ry1 > 479) ry1 = 479;
      end
      run_line(rx0, ry0, rx1, ry1, (i % 3 == 0) ? 0 : 2, 8'hFF, "rand");
    end

`ifdef LINE_DRAWER_DASH_EN
    run_line(0, 0, 9, 0, 0, 8'b0101_0101, "dash");
    for (int i = 0; i < 4; i++) begin
      run_line($urandom_range(0, 639), $urandom_range(0, 479),
               $urandom_range(0, 639), $urandom_range(0, 479),
               2, 8'($urandom_range(0, 255)), "dash_rand");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
